// File: rtl/ct2_timer_ctrl.sv
// Sequencing controller for a chain of CT2 4-bit counter stages forming one
// programmable interval timer with one-shot / periodic modes and optional gating.
module ct2_timer_ctrl #(
   parameter int STAGES = 4
) (
   input  logic                  C,
   input  logic                  notR,
   input  logic                  WR,
   input  logic [1:0]            A,
   input  logic [7:0]            DI,
   input  logic                  GATE,
   input  logic [4*STAGES-1:0]   Q,
   output logic [4*STAGES-1:0]   D,
   output logic                  LOAD,
   output logic                  CLR,
   output logic [STAGES-1:0]     E,
   output logic                  TC,
   output logic                  OUT,
   output logic                  BUSY
);
   localparam int N = 4 * STAGES;

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_e;

   state_e       state_q, state_d;
   logic [N-1:0] reload_q, reload_d;
   logic         mode_q, mode_d;
   logic         gate_en_q, gate_en_d;
   logic         tc_q, tc_d;
   logic         out_q, out_d;
   logic [15:0]  reload_ext;
   logic         wr_ctrl, start, stop, cen, term, carry;

   assign wr_ctrl = WR && (A == 2'd2);
   assign start   = wr_ctrl && DI[0];
   assign stop    = wr_ctrl && DI[3];
   assign cen     = ~gate_en_q | GATE;
   assign term    = (state_q == S_RUN) && (&Q) && cen;

   // Reload is kept as a 16-bit image so the high-byte write can drop bits above N-1.
   always_comb begin
      reload_ext = 16'(reload_q);
      if (WR && (A == 2'd0)) reload_ext[7:0]  = DI;
      if (WR && (A == 2'd1)) reload_ext[15:8] = DI;
      reload_d  = reload_ext[N-1:0];
      mode_d    = wr_ctrl ? DI[1] : mode_q;
      gate_en_d = wr_ctrl ? DI[2] : gate_en_q;
   end

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      CLR     = 1'b0;
      LOAD    = 1'b0;
      E       = '0;
      carry   = 1'b1;
      case (state_q)
         S_CLEAR: begin
            CLR     = 1'b1;
            E       = '1;
            state_d = S_IDLE;
         end
         S_IDLE: if (start) state_d = S_LOAD;
         S_LOAD: begin
            LOAD    = 1'b1;
            E       = '1;
            state_d = S_RUN;
         end
         S_RUN: begin
            // Ripple carry is taken from Q so every stage sees it on the same edge.
            for (int i = 0; i < STAGES; i++) begin
               E[i]  = cen & carry;
               carry = carry & (&Q[4*i +: 4]);
            end
            if (term) begin
               if (mode_q) begin
                  LOAD = 1'b1;
                  E    = '1;
               end else begin
                  state_d = S_DONE;
               end
            end
            if (start) state_d = S_LOAD;
         end
         S_DONE: if (start) state_d = S_LOAD;
         default: state_d = S_CLEAR;
      endcase
      if (stop) state_d = S_CLEAR;
   end

   always_comb begin
      tc_d = term && (state_d != S_CLEAR);
      if (state_d == S_CLEAR)  out_d = 1'b0;
      else if (!mode_q)        out_d = (state_d == S_DONE);
      else                     out_d = out_q ^ term;
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge C or posedge notR) begin
      if (notR) begin
         state_q   <= S_CLEAR;
         reload_q  <= '0;
         mode_q    <= 1'b0;
         gate_en_q <= 1'b0;
         tc_q      <= 1'b0;
         out_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         reload_q  <= reload_d;
         mode_q    <= mode_d;
         gate_en_q <= gate_en_d;
         tc_q      <= tc_d;
         out_q     <= out_d;
      end
   end

   assign D    = reload_q;
   assign TC   = tc_q;
   assign OUT  = out_q;
   assign BUSY = (state_q == S_LOAD) || (state_q == S_RUN);

endmodule

// File: tb/tb_ct2_timer_ctrl.sv
// Bench for ct2_timer_ctrl: a behavioural CT2 chain closes the loop, directed
// scenarios use arithmetic expectations, random traffic is checked against a timer model.
module tb_ct2_timer_ctrl;
   localparam int STAGES = 4;
   localparam int N      = 4 * STAGES;
   localparam logic [N-1:0] MAXV = '1;

   localparam int PH_CLEAR = 0, PH_IDLE = 1, PH_LOAD = 2, PH_RUN = 3, PH_DONE = 4;

   logic              C    = 1'b0;
   logic              notR = 1'b0;
   logic              WR   = 1'b0;
   logic [1:0]        A    = 2'd0;
   logic [7:0]        DI   = 8'd0;
   logic              GATE = 1'b1;
   logic [N-1:0]      Q    = 16'h5A5A;
   logic [N-1:0]      D;
   logic              LOAD, CLR, TC, OUT, BUSY;
   logic [STAGES-1:0] E;

   int n_checks = 0;
   int n_errors = 0;

   // Timer model state
   logic [N-1:0] m_cnt    = '0;
   logic [N-1:0] m_reload = '0;
   logic         m_mode   = 1'b0;
   logic         m_gen    = 1'b0;
   logic         m_tc     = 1'b0;
   logic         m_out    = 1'b0;
   int           m_phase  = PH_CLEAR;

   ct2_timer_ctrl #(.STAGES(STAGES)) dut (
      .C(C), .notR(notR), .WR(WR), .A(A), .DI(DI), .GATE(GATE), .Q(Q),
      .D(D), .LOAD(LOAD), .CLR(CLR), .E(E), .TC(TC), .OUT(OUT), .BUSY(BUSY)
   );

   always #5 C = ~C;

   // Behavioural CT2 chain: synchronous clear, per-stage enable, load or increment.
   always @(posedge C) begin
      if (CLR) Q <= '0;
      else begin
         for (int i = 0; i < STAGES; i++)
            if (E[i]) Q[4*i +: 4] <= LOAD ? D[4*i +: 4] : Q[4*i +: 4] + 4'd1;
      end
   end

   // Timer model: counts as a plain N-bit integer with reload/wrap rules.
   always @(posedge C or posedge notR) begin : ref_model
      logic         cen, wc, st, sp, term;
      logic [N-1:0] nc;
      int           nx;
      if (notR) begin
         m_reload <= '0;
         m_mode   <= 1'b0;
         m_gen    <= 1'b0;
         m_phase  <= PH_CLEAR;
         m_tc     <= 1'b0;
         m_out    <= 1'b0;
         // A clock edge during reset sees the clear line high.
         if (C) m_cnt <= '0;
      end else begin
         cen  = !m_gen || GATE;
         wc   = WR && (A == 2'd2);
         st   = wc && DI[0];
         sp   = wc && DI[3];
         term = (m_phase == PH_RUN) && (m_cnt == MAXV) && cen;
         nc   = m_cnt;
         if (m_phase == PH_CLEAR) nc = '0;
         else if (m_phase == PH_LOAD) nc = m_reload;
         else if (m_phase == PH_RUN && cen) begin
            if (m_cnt == MAXV) nc = m_mode ? m_reload : '0;
            else nc = m_cnt + 1'b1;
         end
         nx = m_phase;
         if (m_phase == PH_CLEAR) nx = PH_IDLE;
         else if (m_phase == PH_LOAD) nx = PH_RUN;
         else if (term && !m_mode) nx = PH_DONE;
         if (st && (m_phase == PH_IDLE || m_phase == PH_RUN || m_phase == PH_DONE)) nx = PH_LOAD;
         if (sp) nx = PH_CLEAR;
         m_cnt   <= nc;
         m_phase <= nx;
         m_tc    <= term && (nx != PH_CLEAR);
         if (nx == PH_CLEAR) m_out <= 1'b0;
         else if (!m_mode) m_out <= (nx == PH_DONE);
         else m_out <= m_out ^ term;
         if (WR && A == 2'd0) m_reload <= {m_reload[15:8], DI};
         if (WR && A == 2'd1) m_reload <= {DI, m_reload[7:0]};
         if (wc) begin
            m_mode <= DI[1];
            m_gen  <= DI[2];
         end
      end
   end

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
      WR = 1'b1; A = a; DI = d;
      tick();
      WR = 1'b0; A = 2'd0; DI = 8'd0;
   endtask

   task automatic test_reset();
      #2 notR = 1'b1;
      #1;
      n_checks++; if (CLR !== 1'b1) begin n_errors++; $display("FAIL reset_clr got=%b exp=1", CLR); end
      n_checks++; if (E !== {STAGES{1'b1}}) begin n_errors++; $display("FAIL reset_e got=%b exp=all ones", E); end
      n_checks++; if (LOAD !== 1'b0) begin n_errors++; $display("FAIL reset_load got=%b exp=0", LOAD); end
      n_checks++; if (TC !== 1'b0) begin n_errors++; $display("FAIL reset_tc got=%b exp=0", TC); end
      n_checks++; if (OUT !== 1'b0) begin n_errors++; $display("FAIL reset_out got=%b exp=0", OUT); end
      n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      n_checks++; if (D !== '0) begin n_errors++; $display("FAIL reset_d got=%h exp=0", D); end
      tick();
      notR = 1'b0;
      tick();
      n_checks++; if (Q !== '0) begin n_errors++; $display("FAIL reset_q got=%h exp=0000", Q); end
      n_checks++; if (CLR !== 1'b0 || E !== '0 || BUSY !== 1'b0) begin
         n_errors++; $display("FAIL reset_idle clr=%b e=%b busy=%b exp 0/0/0", CLR, E, BUSY);
      end
   endtask

   task automatic test_oneshot();
      logic [N-1:0] exp_q;
      int           tc_cnt;
      write_reg(2'd0, 8'hFA);
      write_reg(2'd1, 8'hFF);
      write_reg(2'd2, 8'h01);
      tc_cnt = 0;
      for (int j = 1; j <= 10; j++) begin
         tick();
         exp_q = (j <= 6) ? N'(16'hFFFA + j - 1) : '0;
         if (TC === 1'b1) tc_cnt++;
         n_checks++; if (Q !== exp_q) begin n_errors++; $display("FAIL oneshot_q j=%0d got=%h exp=%h", j, Q, exp_q); end
         n_checks++; if (TC !== (j == 7)) begin n_errors++; $display("FAIL oneshot_tc j=%0d got=%b exp=%b", j, TC, j == 7); end
         n_checks++; if (OUT !== (j >= 7)) begin n_errors++; $display("FAIL oneshot_out j=%0d got=%b exp=%b", j, OUT, j >= 7); end
         n_checks++; if (BUSY !== (j <= 6)) begin n_errors++; $display("FAIL oneshot_busy j=%0d got=%b exp=%b", j, BUSY, j <= 6); end
      end
      n_checks++; if (tc_cnt != 1) begin n_errors++; $display("FAIL oneshot_tc_count got=%0d exp=1", tc_cnt); end
   endtask

   task automatic test_periodic();
      logic [N-1:0] exp_q;
      logic         exp_tc, exp_out;
      write_reg(2'd0, 8'hFC);
      write_reg(2'd2, 8'h03);
      exp_out = 1'b0;
      for (int j = 1; j <= 24; j++) begin
         tick();
         exp_q  = N'(16'hFFFC + ((j - 1) % 4));
         exp_tc = (j >= 5) && ((j - 5) % 4 == 0);
         if (exp_tc) exp_out = ~exp_out;
         n_checks++; if (Q !== exp_q) begin n_errors++; $display("FAIL periodic_q j=%0d got=%h exp=%h", j, Q, exp_q); end
         n_checks++; if (TC !== exp_tc) begin n_errors++; $display("FAIL periodic_tc j=%0d got=%b exp=%b", j, TC, exp_tc); end
         n_checks++; if (OUT !== exp_out) begin n_errors++; $display("FAIL periodic_out j=%0d got=%b exp=%b", j, OUT, exp_out); end
      end
   endtask

   task automatic test_gate();
      bit found;
      int k;
      write_reg(2'd2, 8'h06);
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         tick();
         if (TC === 1'b1) found = 1;
      end
      n_checks++; if (!found) begin n_errors++; $display("FAIL gate_sync got=no TC exp=TC within 12 cycles"); end
      GATE = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++; if (Q !== 16'hFFFC) begin n_errors++; $display("FAIL gate_hold i=%0d got=%h exp=fffc", i, Q); end
      end
      GATE = 1'b1;
      k = 3;
      found = 0;
      while (k < 12 && !found) begin
         tick();
         k++;
         if (TC === 1'b1) found = 1;
      end
      n_checks++; if (!found || k != 7) begin n_errors++; $display("FAIL gate_period got=%0d exp=7", k); end
   endtask

   task automatic test_reload_mid();
      bit found;
      int hits[$];
      write_reg(2'd2, 8'h03);
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         tick();
         if (TC === 1'b1) found = 1;
      end
      n_checks++; if (!found) begin n_errors++; $display("FAIL reload_sync got=no TC exp=TC within 12 cycles"); end
      write_reg(2'd0, 8'hFE);
      for (int c = 2; c <= 12; c++) begin
         tick();
         if (TC === 1'b1) hits.push_back(c);
      end
      n_checks++; if (hits.size() < 3) begin n_errors++; $display("FAIL reload_count got=%0d exp>=3", hits.size()); end
      else begin
         n_checks++; if (hits[0] != 4) begin n_errors++; $display("FAIL reload_first got=%0d exp=4", hits[0]); end
         n_checks++; if (hits[1] != 6 || hits[2] != 8) begin
            n_errors++; $display("FAIL reload_short got=%0d,%0d exp=6,8", hits[1], hits[2]);
         end
      end
   endtask

   task automatic test_period_one();
      write_reg(2'd0, 8'hFF);
      write_reg(2'd2, 8'h03);
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (TC !== 1'b1 || Q !== MAXV || LOAD !== 1'b1) begin
            n_errors++; $display("FAIL period_one i=%0d tc=%b q=%h load=%b exp 1/ffff/1", i, TC, Q, LOAD);
         end
      end
   endtask

   task automatic test_stop_start();
      write_reg(2'd0, 8'hF0);
      write_reg(2'd2, 8'h03);
      repeat (3) tick();
      write_reg(2'd2, 8'h09);
      n_checks++; if (CLR !== 1'b1 || LOAD !== 1'b0 || BUSY !== 1'b0) begin
         n_errors++; $display("FAIL stop_clear clr=%b load=%b busy=%b exp 1/0/0", CLR, LOAD, BUSY);
      end
      tick();
      n_checks++; if (CLR !== 1'b0 || Q !== '0 || BUSY !== 1'b0) begin
         n_errors++; $display("FAIL stop_idle clr=%b q=%h busy=%b exp 0/0000/0", CLR, Q, BUSY);
      end
      tick();
      n_checks++; if (Q !== '0 || BUSY !== 1'b0) begin n_errors++; $display("FAIL stop_hold q=%h busy=%b exp 0000/0", Q, BUSY); end
   endtask

   task automatic test_async_reset();
      write_reg(2'd2, 8'h03);
      repeat (4) tick();
      @(negedge C);
      #1 notR = 1'b1;
      #1;
      n_checks++; if (CLR !== 1'b1 || E !== {STAGES{1'b1}} || LOAD !== 1'b0) begin
         n_errors++; $display("FAIL areset_ctl clr=%b e=%b load=%b exp 1/all ones/0", CLR, E, LOAD);
      end
      n_checks++; if (TC !== 1'b0 || OUT !== 1'b0 || BUSY !== 1'b0 || D !== '0) begin
         n_errors++; $display("FAIL areset_out tc=%b out=%b busy=%b d=%h exp 0/0/0/0000", TC, OUT, BUSY, D);
      end
      #1 notR = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (Q !== '0 || TC !== 1'b0 || BUSY !== 1'b0) begin
            n_errors++; $display("FAIL areset_after i=%0d q=%h tc=%b busy=%b exp 0000/0/0", i, Q, TC, BUSY);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      write_reg(2'd1, 8'hFF);
      for (int i = 0; i < 400; i++) begin
         GATE = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) begin
            WR = 1'b1;
            A  = 2'($urandom_range(0, 3));
            case (A)
               2'd0:    d = 8'hF0 | 8'($urandom_range(0, 15));
               2'd1:    d = 8'hFF;
               2'd2: begin
                  d = 8'($urandom) & 8'hF7;
                  if ($urandom_range(0, 9) == 0) d[3] = 1'b1;
               end
               default: d = 8'($urandom);
            endcase
            DI = d;
         end
         tick();
         WR = 1'b0; A = 2'd0; DI = 8'd0;
         n_checks++; if (Q !== m_cnt) begin n_errors++; $display("FAIL rand_q i=%0d got=%h exp=%h", i, Q, m_cnt); end
         n_checks++; if (TC !== m_tc || OUT !== m_out) begin
            n_errors++; $display("FAIL rand_tc_out i=%0d got=%b%b exp=%b%b", i, TC, OUT, m_tc, m_out);
         end
         n_checks++; if (BUSY !== (m_phase == PH_LOAD || m_phase == PH_RUN) || CLR !== (m_phase == PH_CLEAR)) begin
            n_errors++; $display("FAIL rand_busy_clr i=%0d busy=%b clr=%b phase=%0d", i, BUSY, CLR, m_phase);
         end
         n_checks++; if (D !== m_reload) begin n_errors++; $display("FAIL rand_d i=%0d got=%h exp=%h", i, D, m_reload); end
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_gate();
      test_reload_mid();
      test_period_one();
      test_stop_start();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
